// File: rtl/cam_match_encoder.sv
// Serialises a CAM match bitmap into a stream of matching entry indices, lowest first.
// A search with no hits produces one miss beat. Every output comes straight from a flop.
module cam_match_encoder #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned IDXW  = 4,
    parameter int unsigned CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             match_valid,
    input  logic [WIDTH-1:0] match_vec,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_index,
    output logic             out_hit,
    output logic             out_last,
    output logic [CNTW-1:0]  match_count,
    output logic             overrun,
    input  logic             ovr_clr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_MISS
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  pending, pending_nxt;
    logic [CNTW-1:0]   count_nxt;
    logic              ovr_nxt;
    logic              in_ready_nxt;
    logic              out_valid_nxt;
    logic [IDXW-1:0]   out_index_nxt;
    logic              out_hit_nxt;
    logic              out_last_nxt;
    logic              fire;

    function automatic logic [IDXW-1:0] lowest_set(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = IDXW'(i);
        end
        return idx;
    endfunction

    function automatic logic [CNTW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNTW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CNTW'(v[i]);
        end
        return c;
    endfunction

    function automatic logic single_bit(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    // State, bitmap and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pending     <= '0;
            match_count <= '0;
            overrun     <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_index   <= '0;
            out_hit     <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pending     <= pending_nxt;
            match_count <= count_nxt;
            overrun     <= ovr_nxt;
            in_ready    <= in_ready_nxt;
            out_valid   <= out_valid_nxt;
            out_index   <= out_index_nxt;
            out_hit     <= out_hit_nxt;
            out_last    <= out_last_nxt;
        end
    end

    assign fire = out_valid & out_ready;

    // Next state; output registers are precomputed from the next state and bitmap
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        count_nxt   = match_count;
        ovr_nxt     = overrun;

        case (state)
            ST_IDLE: begin
                if (match_valid) begin
                    pending_nxt = match_vec;
                    count_nxt   = popcount(match_vec);
                    state_nxt   = (match_vec != '0) ? ST_EMIT : ST_MISS;
                end
            end
            ST_EMIT: begin
                if (fire) begin
                    pending_nxt = pending & ~(WIDTH'(1) << out_index);
                    if (out_last) state_nxt = ST_IDLE;
                end
            end
            ST_MISS: begin
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A discarded offer outranks a same-cycle clear
        if (match_valid && (state != ST_IDLE)) begin
            ovr_nxt = 1'b1;
        end else if (ovr_clr) begin
            ovr_nxt = 1'b0;
        end

        in_ready_nxt  = (state_nxt == ST_IDLE);
        out_valid_nxt = (state_nxt != ST_IDLE);
        out_hit_nxt   = (state_nxt == ST_EMIT);
        out_index_nxt = (state_nxt == ST_EMIT) ? lowest_set(pending_nxt) : '0;
        out_last_nxt  = (state_nxt == ST_MISS) ||
                        ((state_nxt == ST_EMIT) && single_bit(pending_nxt));
    end

endmodule

// File: tb/tb_cam_match_encoder.sv
// Directed bench for cam_match_encoder: hits, misses, backpressure, overrun and reset abort.
module tb_cam_match_encoder;

    logic        clk;
    logic        rst_n;
    logic        match_valid;
    logic [13:0] match_vec;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic        out_hit;
    logic        out_last;
    logic [3:0]  match_count;
    logic        overrun;
    logic        ovr_clr;

    int checks = 0;
    int errors = 0;

    cam_match_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .match_valid (match_valid),
        .match_vec   (match_vec),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .out_hit     (out_hit),
        .out_last    (out_last),
        .match_count (match_count),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int idx, input logic hit, input logic last);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".index"}, 32'(out_index), 32'(idx));
        check({tag, ".hit"},   32'(out_hit),   32'(hit));
        check({tag, ".last"},  32'(out_last),  32'(last));
    endtask

    task automatic capture(input logic [13:0] v);
        check("capture.in_ready", 32'(in_ready), 32'd1);
        match_valid = 1'b1;
        match_vec   = v;
        step();
        match_valid = 1'b0;
        match_vec   = '0;
    endtask

    initial begin
        rst_n       = 1'b0;
        match_valid = 1'b0;
        match_vec   = '0;
        out_ready   = 1'b1;
        ovr_clr     = 1'b0;
        #1;
        check("rst.out_valid", 32'(out_valid),   32'd0);
        check("rst.count",     32'(match_count), 32'd0);
        check("rst.overrun",   32'(overrun),     32'd0);
        check("rst.index",     32'(out_index),   32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst.in_ready", 32'(in_ready), 32'd1);

        // Single hit
        capture(14'b00000000000010);
        beat("single", 1, 1'b1, 1'b1);
        check("single.count",    32'(match_count), 32'd1);
        check("single.busy",     32'(in_ready),    32'd0);
        step();
        check("single.in_ready", 32'(in_ready),  32'd1);
        check("single.done",     32'(out_valid), 32'd0);

        // Multi hit
        capture(14'b10000000000101);
        beat("multi0", 0, 1'b1, 1'b0);
        check("multi.count", 32'(match_count), 32'd3);
        step();
        beat("multi1", 2, 1'b1, 1'b0);
        step();
        beat("multi2", 13, 1'b1, 1'b1);
        step();
        check("multi.done",      32'(out_valid),   32'd0);
        check("multi.countheld", 32'(match_count), 32'd3);

        // Miss
        capture(14'b0);
        beat("miss", 0, 1'b0, 1'b1);
        check("miss.count", 32'(match_count), 32'd0);
        step();
        check("miss.in_ready", 32'(in_ready),  32'd1);
        check("miss.done",     32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        capture(14'b00000000110000);
        for (int i = 0; i < 3; i++) begin
            beat("bp.hold", 4, 1'b1, 1'b0);
            step();
        end
        out_ready = 1'b1;
        beat("bp0", 4, 1'b1, 1'b0);
        step();
        beat("bp1", 5, 1'b1, 1'b1);
        step();
        check("bp.done", 32'(out_valid), 32'd0);

        // Overrun while streaming a two-hit search
        out_ready = 1'b0;
        capture(14'b00000000000011);
        check("ovr.pre", 32'(overrun), 32'd0);
        match_valid = 1'b1;
        match_vec   = 14'b00000000000001;
        step();
        match_valid = 1'b0;
        match_vec   = '0;
        check("ovr.set", 32'(overrun), 32'd1);
        beat("ovr.b0", 0, 1'b1, 1'b0);
        out_ready = 1'b1;
        step();
        beat("ovr.b1", 1, 1'b1, 1'b1);
        step();
        check("ovr.done",   32'(out_valid),   32'd0);
        check("ovr.count",  32'(match_count), 32'd2);
        check("ovr.sticky", 32'(overrun),     32'd1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("ovr.clr", 32'(overrun), 32'd0);

        // Clear and new overrun in the same cycle: set wins
        out_ready = 1'b0;
        capture(14'b00000000000001);
        match_valid = 1'b1;
        match_vec   = 14'b00000000000001;
        ovr_clr     = 1'b1;
        step();
        match_valid = 1'b0;
        match_vec   = '0;
        ovr_clr     = 1'b0;
        check("ovr.setwins", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        step();
        check("ovr2.done", 32'(out_valid), 32'd0);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;

        // All-ones bitmap: every index once, last on the top one
        capture(14'h3FFF);
        check("full.count", 32'(match_count), 32'd14);
        for (int i = 0; i < 14; i++) begin
            beat("full", i, 1'b1, (i == 13));
            step();
        end
        check("full.done",      32'(out_valid),   32'd0);
        check("full.countheld", 32'(match_count), 32'd14);

        // Reset during the second beat aborts the stream
        capture(14'h3FFF);
        beat("rmid0", 0, 1'b1, 1'b0);
        step();
        beat("rmid1", 1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rmid.valid", 32'(out_valid),   32'd0);
        check("rmid.count", 32'(match_count), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rmid.in_ready", 32'(in_ready),  32'd1);
        check("rmid.idle",     32'(out_valid), 32'd0);
        capture(14'b00000000001000);
        beat("rmid.fresh", 3, 1'b1, 1'b1);
        check("rmid.count1", 32'(match_count), 32'd1);
        step();
        check("rmid.end", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_match_encoder.md
Name: cam_match_encoder

Overview:
Downstream stage of the image-CAM base RAM. Consumes the 14-bit match bitmap that base_ram drives on dout during a search (match_en high). Serialises every set bit into a stream of matching entry indices over a valid/ready handshake, lowest index first. A search with no set bits produces a single miss beat. Provides match count and overrun status to the search controller.

Parameters:
WIDTH, 14, match bitmap width; equals base_ram data width.
IDXW, 4, index width; must satisfy 2**IDXW >= WIDTH.
CNTW, 4, match count width; must hold the value WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
match_valid  input  1  match_vec holds a valid search result this cycle.
match_vec  input  WIDTH  match bitmap from base_ram dout; bit i set means entry i matched.
in_ready  output  1  encoder is idle and will capture a result presented this cycle.
out_valid  output  1  output beat is valid.
out_ready  input  1  downstream accepts the beat.
out_index  output  IDXW  matching entry index; 0 on a miss beat.
out_hit  output  1  1 for a hit beat, 0 for a miss beat.
out_last  output  1  final beat for the current search.
match_count  output  CNTW  popcount of the last captured bitmap.
overrun  output  1  sticky: a result was offered while busy and was discarded.
ovr_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; pending bitmap 0; match_count 0; overrun 0; out_valid 0; out_index 0; out_hit 0; out_last 0; in_ready 1 after release.
- States: IDLE, EMIT, MISS.
- IDLE: in_ready=1, out_valid=0. On match_valid, register match_vec into pending, register its popcount into match_count, then go to EMIT if the vector is nonzero, else go to MISS.
- Latency: capture on edge N; first beat valid in cycle N+1.
- EMIT:
  - out_valid=1, out_hit=1.
  - out_index = position of the lowest set bit of pending.
  - out_last=1 when pending has exactly one bit set.
  - On out_valid and out_ready: clear that bit in pending. If out_last, go to IDLE; otherwise stay in EMIT.
- MISS: out_valid=1, out_hit=0, out_index=0, out_last=1. On out_ready, go to IDLE.
- Backpressure: while out_valid=1 and out_ready=0, out_index, out_hit and out_last hold stable. Beats are never dropped or reordered.
- Throughput: in_ready returns high in the cycle after the last beat is accepted. A search with K hits occupies K+1 cycles minimum, and 2 cycles for a miss.
- All outputs are driven only from registers and state. There is no combinational path from match_valid or match_vec to any output. out_ready may combinationally affect nothing but the next state.
- Overrun:
  - match_valid high while in_ready=0 discards the vector and sets overrun on the next edge.
  - If ovr_clr and a new overrun occur in the same cycle, set wins.
  - ovr_clr in any other cycle clears overrun.
- match_count holds its value until the next capture, including after the stream ends.
- Bits of match_vec at or above WIDTH do not exist; the all-ones vector produces WIDTH beats, indices 0..WIDTH-1, with out_last on WIDTH-1.
- Reset asserted mid-stream aborts the stream immediately with no final beat. On release the block is in IDLE.

Test Plan:
- Single hit: match_vec=14'b00000000000010, out_ready=1 -> one beat: index 1, hit 1, last 1; match_count=1; in_ready high 2 cycles after capture.
- Multi hit: match_vec=14'b10000000000101, out_ready=1 -> beats with index 0, 2, 13 on consecutive cycles; last only on 13; match_count=3.
- Miss: match_vec=0 -> one beat: hit 0, index 0, last 1; match_count=0.
- Backpressure: vector 14'b00000000110000 with out_ready=0 for 3 cycles -> index 4 held stable; then out_ready=1 -> index 4 then 5 (last).
- Overrun: present 14'b00000000000001 while EMIT of a prior 2-hit search -> vector ignored, overrun=1, stream unaffected; ovr_clr pulse -> overrun=0; ovr_clr together with a new overrun -> overrun stays 1.
- Reset mid-stream: drop rst_n during the second beat of 14'b11111111111111 -> out_valid=0 and match_count=0 immediately; after release in_ready=1, and a fresh capture of 14'b00000000001000 yields index 3.
